iris_seq_ctrl: RTL and testbench

Top-level sequencer for the Iris classifier pipeline. It accepts one feature sample per request handshake, then runs three stages in order: hidden layer, output layer and arg-max. It captures the winning class index and presents it on a valid/ready output. A per-stage watchdog aborts a hung stage, and the block keeps a completed-sample counter.

---
 rtl/iris_seq_pkg.sv | 22 ++
 rtl/seq_watchdog.sv | 34 +++
 rtl/iris_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_iris_seq_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iris_seq_pkg.sv
// Shared types and defaults for the Iris classifier sequencer.
//   seq_state_t   : sequencer FSM states
//   class_t       : arg-max class index (0..2)
//   TIMEOUT_DEF   : default per-stage watchdog limit in cycles
//   CNT_WIDTH_DEF : default width of the completed-sample counter
package iris_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        L1,
        L2,
        AM,
        HOLD,
        ERR
    } seq_state_t;

    typedef logic [1:0] class_t;

    localparam int TIMEOUT_DEF   = 64;
    localparam int CNT_WIDTH_DEF = 16;

endpackage

// File: rtl/seq_watchdog.sv
// Per-stage watchdog for the Iris sequencer.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clear  : restart the count (asserted on entry to a stage)
//   evt    : the running stage has completed this cycle
//   expire : count reached TIMEOUT-1 and the stage did not complete
module seq_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic evt,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // Saturates at LAST so an idle sequencer never wraps back into range.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A completion on the final cycle beats the timeout.
    assign expire = (cnt == LAST) && !evt;

endmodule

// File: rtl/iris_seq_ctrl.sv
// Top-level sequencer for the Iris classifier pipeline.
// Accepts a sample, runs hidden layer, output layer and arg-max in order,
// then holds the winning class on a valid/ready output.
//   in_valid/in_ready     : sample request handshake (ready only in IDLE)
//   l1_start/l1_done      : hidden layer start pulse / done pulse
//   l2_start/l2_done      : output layer start pulse / done pulse
//   am_en/am_run/am_ready : arg-max enable, run level, result valid
//   am_class              : arg-max class index
//   out_valid/out_ready   : result handshake, out_class registered result
//   busy                  : high outside IDLE
//   err_clr/timeout_err   : sticky watchdog flag and its clear
//   sample_cnt            : count of completed output handshakes (wraps)
module iris_seq_ctrl
    import iris_seq_pkg::*;
#(
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 l1_start,
    input  logic                 l1_done,
    output logic                 l2_start,
    input  logic                 l2_done,
    output logic                 am_en,
    output logic                 am_run,
    input  logic                 am_ready,
    input  class_t               am_class,
    output logic                 out_valid,
    input  logic                 out_ready,
    output class_t               out_class,
    output logic                 busy,
    input  logic                 err_clr,
    output logic                 timeout_err,
    output logic [CNT_WIDTH-1:0] sample_cnt
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       stage_first;
    logic       armed;
    logic       wd_clear;
    logic       wd_event;
    logic       wd_expire;

    // Completion of the running stage; a done on the start cycle is ignored.
    always_comb begin
        wd_event = 1'b0;
        case (state)
            L1:      wd_event = l1_done && !stage_first;
            L2:      wd_event = l2_done && !stage_first;
            AM:      wd_event = am_ready;
            default: wd_event = 1'b0;
        endcase
    end

    assign wd_clear = (state_nxt != state);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .evt    (wd_event),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            stage_first <= 1'b0;
            armed       <= 1'b0;
        end else begin
            state       <= state_nxt;
            stage_first <= (state_nxt != state);
            // Keeps in_ready low for the first cycle after reset releases.
            armed       <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        l1_start  = 1'b0;
        l2_start  = 1'b0;
        am_en     = 1'b0;
        am_run    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = armed;
                if (in_valid && armed) state_nxt = L1;
            end
            L1: begin
                l1_start = stage_first;
                if (wd_event)       state_nxt = L2;
                else if (wd_expire) state_nxt = ERR;
            end
            L2: begin
                l2_start = stage_first;
                if (wd_event)       state_nxt = AM;
                else if (wd_expire) state_nxt = ERR;
            end
            AM: begin
                am_en  = 1'b1;
                am_run = 1'b1;
                if (wd_event)       state_nxt = HOLD;
                else if (wd_expire) state_nxt = ERR;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result register, sample counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_class   <= '0;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == AM && am_ready) begin
                out_class <= am_class;
            end
            if (state == HOLD && out_ready) begin
                sample_cnt <= sample_cnt + 1'b1;
            end
            // Entering ERR only happens on expiry; the set beats err_clr.
            if (state_nxt == ERR && state != ERR) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_iris_seq_ctrl.sv
module tb_iris_seq_ctrl;

    localparam int TO = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          l1_start;
    logic          l1_done;
    logic          l2_start;
    logic          l2_done;
    logic          am_en;
    logic          am_run;
    logic          am_ready;
    logic [1:0]    am_class;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_class;
    logic          busy;
    logic          err_clr;
    logic          timeout_err;
    logic [CW-1:0] sample_cnt;

    int            n_vec = 0;
    int            n_err = 0;
    logic [1:0]    exp_q[$];
    logic [1:0]    sb_exp;
    logic [CW-1:0] exp_cnt;
    logic [1:0]    cls_tab[5];
    logic [CW-1:0] wrap_exp[5];

    always #5 clk = ~clk;

    iris_seq_ctrl #(
        .TIMEOUT   (TO),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .l1_start    (l1_start),
        .l1_done     (l1_done),
        .l2_start    (l2_start),
        .l2_done     (l2_done),
        .am_en       (am_en),
        .am_run      (am_run),
        .am_ready    (am_ready),
        .am_class    (am_class),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .busy        (busy),
        .err_clr     (err_clr),
        .timeout_err (timeout_err),
        .sample_cnt  (sample_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output handshake must match the oldest pushed class.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed output class %0d expected no output", out_class);
            end
            if (exp_q.size() != 0) begin
                sb_exp = exp_q.pop_front();
                assert (out_class === sb_exp) else begin
                    n_err++;
                    $error("FAIL sb_class: observed %0d expected %0d", out_class, sb_exp);
                end
            end
        end
    end

    // Runs one sample from IDLE up to the first HOLD cycle.
    // d1/d2/d3: cycle within L1/L2/AM (1 = start cycle) where done/ready arrives.
    task automatic do_sample(input int d1, input int d2, input int d3,
                             input logic [1:0] cls, input bit early);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("l1_start", l1_start, 1);
        chk("busy_l1", busy, 1);
        if (early) begin
            l1_done = 1'b1;
            tick();
            l1_done = 1'b0;
            chk("early_done_ignored", l2_start, 0);
            chk("l1_start_once", l1_start, 0);
            repeat (d1 - 2) tick();
        end else begin
            repeat (d1 - 1) tick();
        end
        l1_done = 1'b1;
        tick();
        l1_done = 1'b0;
        chk("l2_start", l2_start, 1);
        repeat (d2 - 1) tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        chk("am_run", am_run, 1);
        chk("am_en", am_en, 1);
        repeat (d3 - 1) tick();
        am_ready = 1'b1;
        am_class = cls;
        exp_q.push_back(cls);
        tick();
        am_ready = 1'b0;
        am_class = 2'd3;
        chk("out_valid_hold", out_valid, 1);
        chk("am_run_off", am_run, 0);
    endtask

    // Holds the result for 'stall' cycles, then completes the handshake.
    task automatic hold_and_release(input int stall, input logic [1:0] cls);
        for (int i = 0; i < stall; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_class", out_class, cls);
            chk("bp_in_ready", in_ready, 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("out_class", out_class, cls);
        tick();
        exp_cnt = exp_cnt + 1'b1;
        chk("sample_cnt", sample_cnt, exp_cnt);
        chk("out_valid_done", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        l1_done   = 1'b0;
        l2_done   = 1'b0;
        am_ready  = 1'b0;
        am_class  = 2'd0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        exp_cnt   = '0;
        cls_tab   = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0};
        wrap_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sample_cnt", sample_cnt, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_out_class", out_class, 0);
        chk("rst_am_run", am_run, 0);
        rst = 1'b0;
        chk("rst_release_in_ready", in_ready, 0);
        tick();
        chk("in_ready_rise", in_ready, 1);

        // Nominal: l1_done edge 3, l2_done edge 6, am_ready edge 12, class 2
        do_sample(3, 3, 6, 2'd2, 1'b0);
        hold_and_release(0, 2'd2);

        // Output backpressure for 5 cycles, class 1
        do_sample(2, 2, 3, 2'd1, 1'b0);
        hold_and_release(5, 2'd1);

        // Watchdog in L2: never done
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        l1_done = 1'b1;
        tick();
        l1_done = 1'b0;
        chk("wd_l2_start", l2_start, 1);
        for (int i = 1; i < TO; i++) begin
            chk("wd_running", timeout_err, 0);
            tick();
        end
        chk("wd_last_cycle_err", timeout_err, 0);
        chk("wd_last_cycle_busy", busy, 1);
        tick();
        chk("wd_err_flag", timeout_err, 1);
        chk("wd_err_busy", busy, 1);
        chk("wd_err_out_valid", out_valid, 0);
        chk("wd_err_in_ready", in_ready, 0);
        tick();
        chk("wd_idle_busy", busy, 0);
        chk("wd_idle_in_ready", in_ready, 1);
        chk("wd_sticky", timeout_err, 1);
        chk("wd_cnt_unchanged", sample_cnt, exp_cnt);
        chk("wd_class_kept", out_class, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 0);

        // Expiry tie: l1_done on the 8th cycle of L1
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        l1_done = 1'b1;
        tick();
        l1_done = 1'b0;
        chk("tie_l2_start", l2_start, 1);
        chk("tie_no_err", timeout_err, 0);
        tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        chk("tie_am_run", am_run, 1);
        am_ready = 1'b1;
        am_class = 2'd1;
        exp_q.push_back(2'd1);
        tick();
        am_ready = 1'b0;
        chk("tie_out_valid", out_valid, 1);
        hold_and_release(0, 2'd1);

        // err_clr on the expiry cycle: set wins
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwins_flag", timeout_err, 1);
        tick();
        chk("setwins_idle", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("setwins_clr", timeout_err, 0);

        // Reset during AM
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        l1_done = 1'b1;
        tick();
        l1_done = 1'b0;
        tick();
        l2_done = 1'b1;
        tick();
        l2_done = 1'b0;
        chk("mid_am_run", am_run, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_am_run", am_run, 0);
        chk("mrst_am_en", am_en, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_class", out_class, 0);
        chk("mrst_sample_cnt", sample_cnt, 0);
        chk("mrst_l1_start", l1_start, 0);
        tick();
        chk("mrst_in_ready_rise", in_ready, 1);
        chk("mrst_cnt", sample_cnt, 0);
        chk("mrst_am_run_off", am_run, 0);
        exp_cnt = '0;

        // Counter wrap with CNT_WIDTH=2: 1, 2, 3, 0, 1
        for (int i = 0; i < 5; i++) begin
            do_sample(3, 2, 2, cls_tab[i], i == 0);
            hold_and_release((i == 1) ? 2 : 0, cls_tab[i]);
            chk("wrap_seq", sample_cnt, wrap_exp[i]);
        end

        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
